// File: rtl/fetch_unit_pkg.sv
// ============================================================================
// Module      : fetch_unit_pkg
// Description : Shared constants and the {pc, inst} entry type for the
//               instruction-fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_unit_pkg;

    localparam int          c_INST_W   = 32;
    localparam logic [31:0] c_NOP      = 32'h0000_0013;
    localparam logic [31:0] c_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] c_PC_STEP  = 32'd4;

    typedef struct packed {
        logic [31:0]         pc;
        logic [c_INST_W-1:0] inst;
    } fetch_entry_t;

    // Sequential fetch address; wraps modulo 2^32.
    function automatic logic [31:0] next_pc(input logic [31:0] pc);
        return pc + c_PC_STEP;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_unit_fifo.sv
// ============================================================================
// Module      : fetch_fifo
// Description : Parameterised synchronous prefetch FIFO holding {pc, inst}
//               entries, with push, pop, flush and occupancy count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_fifo
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  fetch_entry_t               wdata,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output fetch_entry_t               head
);

    localparam int                 c_PTR_W = $clog2(DEPTH);
    localparam logic [c_PTR_W:0]   c_FULL  = (c_PTR_W+1)'(DEPTH);

    fetch_entry_t               r_mem [DEPTH];
    logic [c_PTR_W-1:0]         r_wr_ptr;
    logic [c_PTR_W-1:0]         r_rd_ptr;
    logic [c_PTR_W:0]           r_count;
    logic                       w_push;
    logic                       w_pop;

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_pop  = pop  & (r_count != '0);
    assign w_push = push & ((r_count != c_FULL) | w_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_rd_ptr <= r_wr_ptr;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (!reset && !flush && w_push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    assign count = r_count;
    assign empty = (r_count == '0);
    assign head  = r_mem[r_rd_ptr];

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// Module      : fetch_unit
// Description : Instruction-fetch stage: owns the fetch PC, registers memory
//               words into a prefetch FIFO and handles redirects.
//               Optional misaligned-target trap: FETCH_ALIGN_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = c_RESET_PC,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] mem_pc,
    input  logic [31:0] mem_inst,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    output logic        misalign_exc,
    output logic [31:0] misalign_pc
`endif
);

    localparam int               c_CNT_W = $clog2(DEPTH) + 1;
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);

    logic [31:0]          r_fetch_pc;
    logic [c_CNT_W-1:0]   w_count;
    logic                 w_empty;
    fetch_entry_t         w_head;
    fetch_entry_t         w_wdata;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_stall;
    logic                 w_load_target;

`ifdef FETCH_ALIGN_CHECK_EN
    logic r_stall;
    logic w_misaligned;

    assign w_misaligned  = redirect & (redirect_pc[1:0] != 2'b00);
    assign w_stall       = r_stall;
    assign w_load_target = redirect & !w_misaligned;

    // A misaligned target parks fetch until the next redirect or reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall      <= 1'b0;
            misalign_exc <= 1'b0;
            misalign_pc  <= 32'h0;
        end else begin
            misalign_exc <= w_misaligned;
            if (redirect) begin
                r_stall <= w_misaligned;
            end
            if (w_misaligned) begin
                misalign_pc <= redirect_pc;
            end
        end
    end
`else
    assign w_stall       = 1'b0;
    assign w_load_target = redirect;
`endif

    // A redirect flushes decode too, so any handshake in that cycle is void.
    assign w_pop   = if_valid & if_ready & !redirect;
    assign w_push  = !redirect & !w_stall & ((w_count < c_FULL) | w_pop);
    assign w_wdata = '{pc: r_fetch_pc, inst: mem_inst};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_pc <= RESET_PC;
        end else if (w_load_target) begin
            r_fetch_pc <= redirect_pc & ~32'h3;
        end else if (w_push) begin
            r_fetch_pc <= next_pc(r_fetch_pc);
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .flush (redirect),
        .wdata (w_wdata),
        .count (w_count),
        .empty (w_empty),
        .head  (w_head)
    );

    assign mem_pc   = r_fetch_pc;
    assign if_valid = !w_empty;
    assign if_pc    = w_empty ? 32'h0 : w_head.pc;
    assign if_inst  = w_empty ? c_NOP : w_head.inst;

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// Module      : tb_fetch_unit
// Description : Scoreboard bench for fetch_unit (default build).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] mem_pc;
    logic [31:0] mem_inst;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        redirect;
    logic [31:0] redirect_pc;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] expq [$];
    logic [63:0] r_exp;

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return pc ^ 32'h00A0_0513;
    endfunction

    assign mem_inst = inst_of(mem_pc);

    fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .mem_pc      (mem_pc),
        .mem_inst    (mem_inst),
        .if_valid    (if_valid),
        .if_ready    (if_ready),
        .if_pc       (if_pc),
        .if_inst     (if_inst),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_push(input logic [31:0] pc);
        expq.push_back({pc, inst_of(pc)});
    endtask

    // Every accepted handshake must match the next expected entry.
    always @(negedge clk) begin
        if (reset === 1'b0 && redirect === 1'b0 && if_valid === 1'b1 && if_ready === 1'b1) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pop: got pc %h expected no entry", if_pc);
            end else begin
                r_exp = expq.pop_front();
                chk("pop_pc", if_pc, r_exp[63:32]);
                chk("pop_inst", if_inst, r_exp[31:0]);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        // Reset then streaming with if_ready=1
        reset = 1'b1; if_ready = 1'b1; redirect = 1'b0; redirect_pc = 32'h0;
        step(); step();
        reset = 1'b0;
        exp_push(32'h0); exp_push(32'h4); exp_push(32'h8);
        @(negedge clk);
        chk("rst_mem_pc", mem_pc, 32'h0);
        chk("rst_if_valid", {31'b0, if_valid}, 32'h0);
        chk("rst_if_pc", if_pc, 32'h0);
        chk("rst_if_inst", if_inst, 32'h0000_0013);
        for (int i = 1; i <= 3; i++) begin
            step();
            @(negedge clk);
            chk("stream_mem_pc", mem_pc, 32'(4 * i));
        end
        step();
        if_ready = 1'b0; reset = 1'b1;
        chk("stream_drained", 32'(expq.size()), 32'h0);

        // Stall with if_ready=0, then release with no bubble
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("stall_empty", {31'b0, if_valid}, 32'h0);
        for (int i = 1; i <= 5; i++) begin
            step();
            @(negedge clk);
            chk("stall_mem_pc", mem_pc, (i == 1) ? 32'h4 : 32'h8);
            chk("stall_if_pc", if_pc, 32'h0);
        end
        step();
        if_ready = 1'b1;
        exp_push(32'h0); exp_push(32'h4); exp_push(32'h8);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i < 2) step();
        end

        // Redirect while full with if_ready=1
        step();
        chk("release_drained", 32'(expq.size()), 32'h0);
        redirect = 1'b1; redirect_pc = 32'h0000_0100;
        @(negedge clk);
        chk("redir_full_valid", {31'b0, if_valid}, 32'h1);
        step();
        redirect = 1'b0;
        exp_push(32'h100); exp_push(32'h104);
        @(negedge clk);
        chk("redir_valid_low", {31'b0, if_valid}, 32'h0);
        chk("redir_mem_pc", mem_pc, 32'h100);
        step();
        @(negedge clk);
        chk("redir_if_pc", if_pc, 32'h100);
        step();
        @(negedge clk);
        step();
        if_ready = 1'b0;
        chk("redir_drained", 32'(expq.size()), 32'h0);

        // PC wrap at the top of the address space
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect = 1'b0;
        @(negedge clk);
        chk("wrap_mem_pc_top", mem_pc, 32'hFFFF_FFFC);
        chk("wrap_valid_low", {31'b0, if_valid}, 32'h0);
        step();
        @(negedge clk);
        chk("wrap_mem_pc_zero", mem_pc, 32'h0);
        chk("wrap_if_pc", if_pc, 32'hFFFF_FFFC);
        step();
        if_ready = 1'b1;
        exp_push(32'hFFFF_FFFC); exp_push(32'h0);
        @(negedge clk);
        step();
        @(negedge clk);
        step();
        if_ready = 1'b0;
        chk("wrap_drained", 32'(expq.size()), 32'h0);

        // Unaligned target is forced to a word boundary in this build
        redirect = 1'b1; redirect_pc = 32'h0000_0102;
        step();
        redirect = 1'b0;
        @(negedge clk);
        chk("align_mem_pc", mem_pc, 32'h100);
        chk("align_valid_low", {31'b0, if_valid}, 32'h0);
        step();
        @(negedge clk);
        chk("align_if_pc", if_pc, 32'h100);
        chk("align_if_inst", if_inst, inst_of(32'h100));

        // Reset together with redirect: reset wins
        step();
        reset = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0200; if_ready = 1'b1;
        expq.delete();
        step();
        reset = 1'b0; redirect = 1'b0; if_ready = 1'b0;
        @(negedge clk);
        chk("rstredir_mem_pc", mem_pc, 32'h0);
        chk("rstredir_valid", {31'b0, if_valid}, 32'h0);
        chk("rstredir_if_inst", if_inst, 32'h0000_0013);
        chk("rstredir_if_pc", if_pc, 32'h0);
        step();
        @(negedge clk);
        chk("rstredir_first_pc", if_pc, 32'h0);
        chk("rstredir_next_mem_pc", mem_pc, 32'h4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
